// File: rtl/branch_resolve_if.sv
// Instruction/flag inputs and resolved-result outputs of the branch resolve stage.
// master drives instructions and consumes results; slave is the resolve stage.
interface branch_resolve_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_kind;
    logic [2:0]      in_cond;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_target;
    logic            cmp_n;
    logic            cmp_z;
    logic            cmp_sn;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_redirect;
    logic            out_fault;
    logic [3:0]      flags;

    modport master (
        output in_valid, in_kind, in_cond, in_pc, in_target,
        output cmp_n, cmp_z, cmp_sn, flush, out_ready,
        input  in_ready, out_valid, out_taken, out_pc, out_redirect, out_fault, flags
    );

    modport slave (
        input  in_valid, in_kind, in_cond, in_pc, in_target,
        input  cmp_n, cmp_z, cmp_sn, flush, out_ready,
        output in_ready, out_valid, out_taken, out_pc, out_redirect, out_fault, flags
    );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: latches CMP flags, resolves branches/jumps, single-entry output.
// Optional BRANCH_PERF_EN adds taken/not-taken counters for conditional branches.
module branch_resolve #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_resolve_if.slave bus
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0]     perf_taken,
    output logic [31:0]     perf_not_taken
`endif
);

    typedef enum logic {StEmpty, StFull} state_e;

    localparam logic [1:0] KindCmp  = 2'd1;
    localparam logic [1:0] KindBr   = 2'd2;
    localparam logic [1:0] KindJump = 2'd3;

    state_e          state_q, state_d;
    logic            taken_q, fault_q;
    logic [XLEN-1:0] pc_q, redirect_q;
    // {f_valid, f_sn, f_z, f_n}
    logic [3:0]      flags_q;

    logic            accept;
    logic            cond_met;
    logic            res_taken;
    logic            res_fault;
    logic [XLEN-1:0] res_redirect;

    assign bus.out_valid    = (state_q == StFull);
    assign bus.in_ready     = !bus.flush && (!bus.out_valid || bus.out_ready);
    assign bus.out_taken    = taken_q;
    assign bus.out_fault    = fault_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_redirect = redirect_q;
    assign bus.flags        = flags_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        cond_met = 1'b0;
        case (bus.in_cond)
            3'd0:    cond_met = flags_q[1];
            3'd1:    cond_met = !flags_q[1];
            3'd2:    cond_met = flags_q[0];
            3'd3:    cond_met = !flags_q[0];
            3'd4:    cond_met = flags_q[2];
            3'd5:    cond_met = !flags_q[2];
            3'd6:    cond_met = flags_q[2] | flags_q[1];
            default: cond_met = !(flags_q[2] | flags_q[1]);
        endcase
    end

    always_comb begin
        res_taken = 1'b0;
        res_fault = 1'b0;
        case (bus.in_kind)
            KindBr: begin
                if (flags_q[3]) begin
                    res_taken = cond_met;
                end else begin
                    res_fault = 1'b1;
                end
            end
            KindJump: res_taken = 1'b1;
            default:  res_taken = 1'b0;
        endcase
        res_redirect = res_taken ? bus.in_target : bus.in_pc + XLEN'(4);
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            state_d = StFull;
        end else if (state_q == StFull && bus.out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q    <= 1'b0;
            fault_q    <= 1'b0;
            pc_q       <= '0;
            redirect_q <= '0;
        end else if (accept) begin
            taken_q    <= res_taken;
            fault_q    <= res_fault;
            pc_q       <= bus.in_pc;
            redirect_q <= res_redirect;
        end
    end

    // Flags only move on an accepted CMP; a flushed CMP is never accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (accept && bus.in_kind == KindCmp) begin
            flags_q <= {1'b1, bus.cmp_sn, bus.cmp_z, bus.cmp_n};
        end
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_taken_q, perf_not_taken_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_taken_q     <= '0;
            perf_not_taken_q <= '0;
        end else if (accept && bus.in_kind == KindBr) begin
            if (res_taken) begin
                perf_taken_q <= perf_taken_q + 32'd1;
            end else begin
                perf_not_taken_q <= perf_not_taken_q + 32'd1;
            end
        end
    end

    assign perf_taken     = perf_taken_q;
    assign perf_not_taken = perf_not_taken_q;
`endif

endmodule
